// File: rtl/mc_sequencer.sv
// mc_sequencer -- multi-cycle control sequencer for a small MIPS-style datapath.
//
// The FSM walks BOOT -> INTR -> FETCH -> DECODE -> EXEC -> MEM -> WB. Every
// instruction ends at a "boundary", where a pending INT diverts to INTR and
// otherwise the FSM returns to FETCH. The outputs are decoded from the state
// and the live IR fields (opCode/fnCode), zero and mem_ready. The IR holds the
// instruction until the boundary, so this block keeps no copy of the opcode.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   INT                  level interrupt, sampled only at instruction boundaries
//   opCode, fnCode       ins[31:26], ins[5:0] from the IR
//   zero                 ALU zero flag (for beq)
//   mem_ready            memory handshake; the access completes on a high cycle
//   ir_we, pc_we, RegWrite, MemRead, MemWrite   datapath strobes
//   RegDst, ALUSrc, Mem2Reg                     datapath mux selects
//   op[2:0]              ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//   pc_sel[1:0]          0 PC+4, 1 branch target, 2 jump target, 3 entryPoint
//   state[2:0]           current FSM state, for debug
//   retired[31:0]        instructions retired (only with MC_SEQUENCER_RETIRE_CNT_EN)
//
// Optional feature macro: MC_SEQUENCER_RETIRE_CNT_EN adds the retired counter.

module mc_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic [5:0] opCode,
    input  logic [5:0] fnCode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       Mem2Reg,
    output logic [2:0] op,
    output logic [1:0] pc_sel,
    output logic [2:0] state
`ifdef MC_SEQUENCER_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        INTR   = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t cur, nxt;
    logic   boundary;   // the current cycle ends an instruction
    state_t bnd_state;

    assign state     = cur;
    assign bnd_state = INT ? INTR : FETCH;

    // R-type funct -> ALU op; unknown functs fall back to add.
    function automatic logic [2:0] alu_from_fn(input logic [5:0] fn);
        case (fn)
            6'h20:   alu_from_fn = 3'b010;
            6'h22:   alu_from_fn = 3'b110;
            6'h24:   alu_from_fn = 3'b000;
            6'h25:   alu_from_fn = 3'b001;
            6'h2A:   alu_from_fn = 3'b111;
            default: alu_from_fn = 3'b010;
        endcase
    endfunction

    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        Mem2Reg  = 1'b0;
        op       = 3'b000;
        pc_sel   = 2'd0;
        boundary = 1'b0;
        nxt      = cur;
        case (cur)
            BOOT: nxt = INTR;
            INTR: begin
                pc_we  = 1'b1;
                pc_sel = 2'd3;
                nxt    = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                if (mem_ready) nxt = DECODE;
            end
            DECODE: begin
                case (opCode)
                    OP_J: begin
                        pc_we    = 1'b1;
                        pc_sel   = 2'd2;
                        boundary = 1'b1;
                    end
                    OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW: nxt = EXEC;
                    default: boundary = 1'b1;   // unsupported: retire as NOP
                endcase
            end
            EXEC: begin
                case (opCode)
                    OP_RTYPE: begin
                        op  = alu_from_fn(fnCode);
                        nxt = WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc = 1'b1;
                        op     = 3'b010;
                        nxt    = MEM;
                    end
                    OP_ADDI: begin
                        ALUSrc = 1'b1;
                        op     = 3'b010;
                        nxt    = WB;
                    end
                    OP_BEQ: begin
                        op       = 3'b110;
                        pc_sel   = 2'd1;
                        pc_we    = zero;
                        boundary = 1'b1;
                    end
                    default: boundary = 1'b1;
                endcase
            end
            MEM: begin
                MemRead  = (opCode == OP_LW);
                MemWrite = (opCode == OP_SW);
                if (mem_ready) begin
                    if (opCode == OP_LW) nxt = WB;
                    else                 boundary = 1'b1;
                end
            end
            WB: begin
                RegWrite = 1'b1;
                RegDst   = (opCode == OP_RTYPE);
                Mem2Reg  = (opCode == OP_LW);
                boundary = 1'b1;
            end
            default: nxt = BOOT;   // encoding 7 is never entered; recover
        endcase
        if (boundary) nxt = bnd_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= BOOT;
        else        cur <= nxt;
    end

`ifdef MC_SEQUENCER_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        retired <= 32'd0;
        else if (boundary) retired <= retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: a cycle-by-cycle vector table covering
// every instruction class, then hand-written asynchronous reset sequences.
module tb_mc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       INT = 1'b0;
    logic [5:0] opCode = 6'h00;
    logic [5:0] fnCode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       ir_we, pc_we, RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Mem2Reg;
    logic [2:0] op;
    logic [1:0] pc_sel;
    logic [2:0] state;
`ifdef MC_SEQUENCER_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    mc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .opCode(opCode), .fnCode(fnCode),
        .zero(zero), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .op(op),
        .pc_sel(pc_sel), .state(state)
`ifdef MC_SEQUENCER_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        intr;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] o;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;

    // {ir_we,pc_we,RegWrite,MemRead,MemWrite,RegDst,ALUSrc,Mem2Reg,op,pc_sel}
    function automatic logic [12:0] o(input logic ir, pc, rw, mr, mw, rd, as, m2r,
                                      input logic [2:0] aop, input logic [1:0] ps);
        return {ir, pc, rw, mr, mw, rd, as, m2r, aop, ps};
    endfunction

    function automatic logic [12:0] outs();
        return {ir_we, pc_we, RegWrite, MemRead, MemWrite, RegDst, ALUSrc, Mem2Reg, op, pc_sel};
    endfunction

    task automatic v(input logic intr, input logic [5:0] opc, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [2:0] st, input logic [12:0] ov);
        vec_t e;
        e.intr = intr; e.opc = opc; e.fn = fn; e.z = z; e.rdy = rdy; e.st = st; e.o = ov;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the next falling edge and check the state observed there.
    task automatic step(input string name, input logic [2:0] st);
        @(negedge clk);
        #2;
        chk(name, {29'd0, state}, {29'd0, st});
    endtask

    logic [12:0] ON, OF, OFW, OI;

    initial begin
        ON  = o(0,0,0,0,0,0,0,0,3'b000,2'd0);
        OF  = o(1,1,0,1,0,0,0,0,3'b000,2'd0);   // fetch, memory ready
        OFW = o(0,0,0,1,0,0,0,0,3'b000,2'd0);   // fetch, memory waiting
        OI  = o(0,1,0,0,0,0,0,0,3'b000,2'd3);

        v(0,6'h00,6'h00,0,1,3'd6,OI);
        // add / sub / and / or / slt / unknown funct
        v(0,6'h00,6'h20,0,1,3'd1,OF); v(0,6'h00,6'h20,0,1,3'd2,ON);
        v(0,6'h00,6'h20,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b010,0)); v(0,6'h00,6'h20,0,1,3'd5,o(0,0,1,0,0,1,0,0,0,0));
        v(0,6'h00,6'h22,0,1,3'd1,OF); v(0,6'h00,6'h22,0,1,3'd2,ON);
        v(0,6'h00,6'h22,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b110,0)); v(0,6'h00,6'h22,0,1,3'd5,o(0,0,1,0,0,1,0,0,0,0));
        v(0,6'h00,6'h24,0,1,3'd1,OF); v(0,6'h00,6'h24,0,1,3'd2,ON);
        v(0,6'h00,6'h24,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b000,0)); v(0,6'h00,6'h24,0,1,3'd5,o(0,0,1,0,0,1,0,0,0,0));
        v(0,6'h00,6'h25,0,1,3'd1,OF); v(0,6'h00,6'h25,0,1,3'd2,ON);
        v(0,6'h00,6'h25,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b001,0)); v(0,6'h00,6'h25,0,1,3'd5,o(0,0,1,0,0,1,0,0,0,0));
        v(0,6'h00,6'h2A,0,1,3'd1,OF); v(0,6'h00,6'h2A,0,1,3'd2,ON);
        v(0,6'h00,6'h2A,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b111,0)); v(0,6'h00,6'h2A,0,1,3'd5,o(0,0,1,0,0,1,0,0,0,0));
        v(0,6'h00,6'h21,0,1,3'd1,OF); v(0,6'h00,6'h21,0,1,3'd2,ON);
        v(0,6'h00,6'h21,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b010,0)); v(0,6'h00,6'h21,0,1,3'd5,o(0,0,1,0,0,1,0,0,0,0));
        // lw: one fetch wait, then two memory waits
        v(0,6'h23,6'h00,0,0,3'd1,OFW); v(0,6'h23,6'h00,0,1,3'd1,OF); v(0,6'h23,6'h00,0,1,3'd2,ON);
        v(0,6'h23,6'h00,0,1,3'd3,o(0,0,0,0,0,0,1,0,3'b010,0));
        v(0,6'h23,6'h00,0,0,3'd4,o(0,0,0,1,0,0,0,0,0,0)); v(0,6'h23,6'h00,0,0,3'd4,o(0,0,0,1,0,0,0,0,0,0));
        v(0,6'h23,6'h00,0,1,3'd4,o(0,0,0,1,0,0,0,0,0,0)); v(0,6'h23,6'h00,0,1,3'd5,o(0,0,1,0,0,0,0,1,0,0));
        // beq taken / not taken
        v(0,6'h04,6'h00,1,1,3'd1,OF); v(0,6'h04,6'h00,1,1,3'd2,ON);
        v(0,6'h04,6'h00,1,1,3'd3,o(0,1,0,0,0,0,0,0,3'b110,1));
        v(0,6'h04,6'h00,0,1,3'd1,OF); v(0,6'h04,6'h00,0,1,3'd2,ON);
        v(0,6'h04,6'h00,0,1,3'd3,o(0,0,0,0,0,0,0,0,3'b110,1));
        // j, unsupported opcode, addi
        v(0,6'h02,6'h00,0,1,3'd1,OF); v(0,6'h02,6'h00,0,1,3'd2,o(0,1,0,0,0,0,0,0,0,2));
        v(0,6'h3F,6'h00,0,1,3'd1,OF); v(0,6'h3F,6'h00,0,1,3'd2,ON);
        v(0,6'h08,6'h00,0,1,3'd1,OF); v(0,6'h08,6'h00,0,1,3'd2,ON);
        v(0,6'h08,6'h00,0,1,3'd3,o(0,0,0,0,0,0,1,0,3'b010,0)); v(0,6'h08,6'h00,0,1,3'd5,o(0,0,1,0,0,0,0,0,0,0));
        // sw with INT raised in EXEC: instruction completes, then INTR
        v(0,6'h2B,6'h00,0,1,3'd1,OF); v(0,6'h2B,6'h00,0,1,3'd2,ON);
        v(1,6'h2B,6'h00,0,1,3'd3,o(0,0,0,0,0,0,1,0,3'b010,0));
        v(1,6'h2B,6'h00,0,0,3'd4,o(0,0,0,0,1,0,0,0,0,0)); v(1,6'h2B,6'h00,0,1,3'd4,o(0,0,0,0,1,0,0,0,0,0));
        v(0,6'h2B,6'h00,0,1,3'd6,OI);
        v(0,6'h02,6'h00,0,1,3'd1,OF); v(0,6'h02,6'h00,0,1,3'd2,o(0,1,0,0,0,0,0,0,0,2));

        // reset held for three cycles
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_outs", {19'd0, outs()}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("boot_state", {29'd0, state}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            INT = tbl[i].intr; opCode = tbl[i].opc; fnCode = tbl[i].fn;
            zero = tbl[i].z; mem_ready = tbl[i].rdy;
            #2;
            chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
            chk($sformatf("vec%0d_outs", i), {19'd0, outs()}, {19'd0, tbl[i].o});
        end

`ifdef MC_SEQUENCER_RETIRE_CNT_EN
        @(negedge clk);
        opCode = 6'h02; mem_ready = 1'b1; INT = 1'b0;
        #2;
        chk("retired_14", retired, 32'd14);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        step("ret_decode", 3'd2);
        step("ret_fetch", 3'd1);
        chk("retired_wrap", retired, 32'd0);
`endif

        // Asynchronous reset in the middle of a waiting FETCH.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_state", {29'd0, state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; INT = 1'b0; opCode = 6'h00; mem_ready = 1'b0;
        step("rst2_intr", 3'd6);
        step("rst2_fetch", 3'd1);
        chk("fetch_wait_memread", {31'd0, MemRead}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("fetch_rst_state", {29'd0, state}, 32'd0);
        chk("fetch_rst_memread", {31'd0, MemRead}, 32'd0);

        // Asynchronous reset in the middle of a waiting lw MEM.
        @(negedge clk);
        rst_n = 1'b1; opCode = 6'h23; mem_ready = 1'b1;
        step("rst3_intr", 3'd6);
        step("rst3_fetch", 3'd1);
        step("rst3_decode", 3'd2);
        step("rst3_exec", 3'd3);
        mem_ready = 1'b0;
        step("rst3_mem", 3'd4);
        chk("mem_wait_memread", {31'd0, MemRead}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mem_rst_state", {29'd0, state}, 32'd0);
        chk("mem_rst_memread", {31'd0, MemRead}, 32'd0);

        // Same for sw: MemWrite must drop with reset.
        @(negedge clk);
        rst_n = 1'b1; opCode = 6'h2B; mem_ready = 1'b1;
        step("rst4_intr", 3'd6);
        step("rst4_fetch", 3'd1);
        step("rst4_decode", 3'd2);
        step("rst4_exec", 3'd3);
        mem_ready = 1'b0;
        step("rst4_mem", 3'd4);
        chk("mem_wait_memwrite", {31'd0, MemWrite}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mem_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("mem_rst_state_sw", {29'd0, state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
